// File: rtl/rd_tcem_split_tracker_if.sv
// Bus between the read capture path / data shifter and rd_tcem_split_tracker.
// Signals:
//   tcem_expired   - pulse from the tCEM timer checker
//   mem_page_size  - log2 page size in bytes (6..15), page-split option only
//   start_track    - command-issue pulse from the data shifter
//   first_addr     - start byte address of the burst
//   wr_rd          - 1 = write (ignored), 0 = read
//   xfer_btype     - 01 = INCR, 10 = WRAP
//   xfer_mem_len   - burst length in 2-byte beats
//   rd_beat_valid  - one captured DDR beat this cycle
//   ce_n_ip        - CE# as driven to the memory (1 = deasserted)
//   rd_split_ack   - data shifter accepted the split request
//   rd_split_req   - re-issue of the remainder required (level)
//   rd_next_addr   - resume byte address
//   rd_rem_len     - beats still owed
//   rd_xfer_done   - one-cycle pulse on completion without a split
// Modports: master = data shifter / capture side, slave = tracker.
interface rd_tcem_split_tracker_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
);
    localparam int unsigned DQS_CNT_WIDTH = (AXI_DATA_WIDTH == 128) ? 12 :
                                            (AXI_DATA_WIDTH == 64)  ? 11 : 10;

    logic                      tcem_expired;
    logic [3:0]                mem_page_size;
    logic                      start_track;
    logic [AXI_ADDR_WIDTH-1:0] first_addr;
    logic                      wr_rd;
    logic [1:0]                xfer_btype;
    logic [DQS_CNT_WIDTH-1:0]  xfer_mem_len;
    logic                      rd_beat_valid;
    logic                      ce_n_ip;
    logic                      rd_split_ack;
    logic                      rd_split_req;
    logic [AXI_ADDR_WIDTH-1:0] rd_next_addr;
    logic [DQS_CNT_WIDTH-1:0]  rd_rem_len;
    logic                      rd_xfer_done;

    modport master (
        output tcem_expired, mem_page_size, start_track, first_addr, wr_rd, xfer_btype,
               xfer_mem_len, rd_beat_valid, ce_n_ip, rd_split_ack,
        input  rd_split_req, rd_next_addr, rd_rem_len, rd_xfer_done
    );

    modport slave (
        input  tcem_expired, mem_page_size, start_track, first_addr, wr_rd, xfer_btype,
               xfer_mem_len, rd_beat_valid, ce_n_ip, rd_split_ack,
        output rd_split_req, rd_next_addr, rd_rem_len, rd_xfer_done
    );
endinterface

// File: rtl/rd_tcem_split_tracker.sv
// Read-side tCEM split tracker. Counts captured read beats of a burst and, when
// tCEM expires (or CE# is dropped early), waits for CE# high and the capture
// pipeline to drain, then asks the data shifter to re-issue the remainder with
// the exact resume address and beat count.
// Ports:
//   mem_clk - memory-side clock
//   rst_n   - asynchronous active-low reset
//   bus     - rd_tcem_split_tracker_if.slave (see interface file for signals)
// Optional build macro RD_PG_BNDRY_SPLIT_EN: INCR reads are also split when a
// beat lands the address on a page boundary (page = 2**mem_page_size bytes).
module rd_tcem_split_tracker #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32
) (
    input logic                    mem_clk,
    input logic                    rst_n,
    rd_tcem_split_tracker_if.slave bus
);
    localparam int unsigned DQS_CNT_WIDTH = (AXI_DATA_WIDTH == 128) ? 12 :
                                            (AXI_DATA_WIDTH == 64)  ? 11 : 10;
    localparam int unsigned AW = AXI_ADDR_WIDTH;
    localparam int unsigned CW = DQS_CNT_WIDTH;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StRdTrack  = 2'd1;
    localparam logic [1:0] StDrain    = 2'd2;
    localparam logic [1:0] StSplitReq = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] addr_cntr_q, addr_cntr_d;
    logic [CW-1:0] rem_cnt_q, rem_cnt_d;
    logic          wrap_q, wrap_d;
    logic [AW-1:0] wrap_mask_q, wrap_mask_d;   // low-bit mask of the wrap window
    logic          split_req_q, split_req_d;
    logic [AW-1:0] next_addr_q, next_addr_d;
    logic [CW-1:0] rem_len_q, rem_len_d;
    logic          xfer_done_q, xfer_done_d;

    logic          beat;
    logic [AW-1:0] addr_inc, addr_adv, addr_nxt;
    logic [CW-1:0] rem_nxt;
    logic          start_wrap;
    logic [AW-1:0] start_mask;
    logic          page_hit;

    // A beat only counts while tracking and while beats are still owed.
    always_comb begin
        beat     = ((state_q == StRdTrack) || (state_q == StDrain)) && bus.rd_beat_valid &&
                   (rem_cnt_q != '0);
        addr_inc = addr_cntr_q + AW'(2);
        addr_adv = wrap_q ? ((addr_cntr_q & ~wrap_mask_q) | (addr_inc & wrap_mask_q)) : addr_inc;
        addr_nxt = beat ? addr_adv : addr_cntr_q;
        rem_nxt  = beat ? (rem_cnt_q - CW'(1)) : rem_cnt_q;
    end

    // Only WRAP lengths 8/16/32 form a window; anything else is tracked as INCR.
    always_comb begin
        start_wrap = 1'b0;
        start_mask = '0;
        if (bus.xfer_btype == 2'b10) begin
            case (bus.xfer_mem_len)
                CW'(8):  begin start_wrap = 1'b1; start_mask = AW'(16'h000F); end
                CW'(16): begin start_wrap = 1'b1; start_mask = AW'(16'h001F); end
                CW'(32): begin start_wrap = 1'b1; start_mask = AW'(16'h003F); end
                default: begin start_wrap = 1'b0; start_mask = '0; end
            endcase
        end
    end

`ifdef RD_PG_BNDRY_SPLIT_EN
    logic [AW-1:0] page_mask;
    always_comb begin
        page_mask = (AW'(1) << bus.mem_page_size) - AW'(1);
        page_hit  = !wrap_q && beat && (bus.mem_page_size >= 4'd6) &&
                    ((addr_adv & page_mask) == '0);
    end
`else
    logic unused_page_size;
    assign unused_page_size = ^bus.mem_page_size;
    assign page_hit         = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_cntr_d = addr_cntr_q;
        rem_cnt_d   = rem_cnt_q;
        wrap_d      = wrap_q;
        wrap_mask_d = wrap_mask_q;
        split_req_d = split_req_q;
        next_addr_d = next_addr_q;
        rem_len_d   = rem_len_q;
        xfer_done_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start_track && !bus.wr_rd) begin
                    addr_cntr_d = bus.first_addr;
                    rem_cnt_d   = bus.xfer_mem_len;
                    wrap_d      = start_wrap;
                    wrap_mask_d = start_mask;
                    state_d     = StRdTrack;
                end
            end
            StRdTrack: begin
                addr_cntr_d = addr_nxt;
                rem_cnt_d   = rem_nxt;
                if (bus.ce_n_ip) begin
                    // Early CE# deassertion with beats owed is handled as a split.
                    if (rem_nxt == '0) begin
                        xfer_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        state_d = StDrain;
                    end
                end else if ((rem_nxt != '0) && (bus.tcem_expired || page_hit)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                addr_cntr_d = addr_nxt;
                rem_cnt_d   = rem_nxt;
                if (bus.ce_n_ip && !bus.rd_beat_valid) begin
                    if (rem_cnt_q == '0) begin
                        xfer_done_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        split_req_d = 1'b1;
                        next_addr_d = addr_cntr_q;
                        rem_len_d   = rem_cnt_q;
                        state_d     = StSplitReq;
                    end
                end
            end
            StSplitReq: begin
                if (bus.rd_split_ack) begin
                    split_req_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_cntr_q <= '0;
            rem_cnt_q   <= '0;
            wrap_q      <= 1'b0;
            wrap_mask_q <= '0;
            split_req_q <= 1'b0;
            next_addr_q <= '0;
            rem_len_q   <= '0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_cntr_q <= addr_cntr_d;
            rem_cnt_q   <= rem_cnt_d;
            wrap_q      <= wrap_d;
            wrap_mask_q <= wrap_mask_d;
            split_req_q <= split_req_d;
            next_addr_q <= next_addr_d;
            rem_len_q   <= rem_len_d;
            xfer_done_q <= xfer_done_d;
        end
    end

    assign bus.rd_split_req = split_req_q;
    assign bus.rd_next_addr = next_addr_q;
    assign bus.rd_rem_len   = rem_len_q;
    assign bus.rd_xfer_done = xfer_done_q;
endmodule

// File: tb/tb_rd_tcem_split_tracker.sv
// Self-checking bench for rd_tcem_split_tracker. Expected completion / split
// events are pushed to a queue when a burst is driven and popped when the DUT
// raises rd_xfer_done or rd_split_req.
module tb_rd_tcem_split_tracker;
    typedef struct {
        bit          is_split;
        logic [31:0] addr;
        logic [9:0]  len;
    } exp_t;

    logic mem_clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    rd_tcem_split_tracker_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

    rd_tcem_split_tracker #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) dut (
        .mem_clk (mem_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    // One clock with the given inputs; returns 1 ns after the edge.
    task automatic cyc(input bit beat, input bit ce_n, input bit tcem, input bit ack);
        bus.rd_beat_valid = beat;
        bus.ce_n_ip       = ce_n;
        bus.tcem_expired  = tcem;
        bus.rd_split_ack  = ack;
        @(posedge mem_clk);
        #1;
        bus.rd_beat_valid = 1'b0;
        bus.tcem_expired  = 1'b0;
        bus.rd_split_ack  = 1'b0;
        bus.start_track   = 1'b0;
    endtask

    task automatic start(input logic [31:0] addr, input logic [9:0] len, input logic [1:0] bt,
                         input bit wr);
        bus.start_track  = 1'b1;
        bus.first_addr   = addr;
        bus.xfer_mem_len = len;
        bus.xfer_btype   = bt;
        bus.wr_rd        = wr;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic beats(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Idles with CE# high until the DUT reports an event or the budget runs out.
    task automatic wait_ev(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (bus.rd_xfer_done || bus.rd_split_req) begin
                timed_out = 1'b0;
                break;
            end
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge mem_clk);
        #1;
        checks++;
        if ({bus.rd_split_req, bus.rd_xfer_done, bus.rd_next_addr, bus.rd_rem_len} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b done=%b addr=%h len=%0d, required all 0",
                     bus.rd_split_req, bus.rd_xfer_done, bus.rd_next_addr, bus.rd_rem_len);
        end
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_incr_done();
        bit   to;
        exp_t e;
        start(32'h100, 10'd16, 2'b01, 1'b0);
        exp_q.push_back('{is_split: 1'b0, addr: 32'h0, len: 10'd0});
        beats(16);
        wait_ev(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL incr_event: got timeout, required rd_xfer_done");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rd_split_req !== e.is_split) begin
                errors++;
                $display("FAIL incr_kind: got req=%b, required %b", bus.rd_split_req, e.is_split);
            end
            checks++;
            if (bus.rd_xfer_done !== !e.is_split) begin
                errors++;
                $display("FAIL incr_done: got %b, required %b", bus.rd_xfer_done, !e.is_split);
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus.rd_xfer_done !== 1'b0 || bus.rd_split_req !== 1'b0) begin
            errors++;
            $display("FAIL incr_pulse: got done=%b req=%b, required 0 0",
                     bus.rd_xfer_done, bus.rd_split_req);
        end
    endtask

    task automatic test_tcem_split();
        bit   to;
        exp_t e;
        start(32'h200, 10'd32, 2'b01, 1'b0);
        exp_q.push_back('{is_split: 1'b1, addr: 32'h218, len: 10'd20});
        beats(10);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        beats(2);
        wait_ev(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL tcem_event: got timeout, required rd_split_req");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rd_split_req !== e.is_split || bus.rd_xfer_done !== 1'b0) begin
                errors++;
                $display("FAIL tcem_kind: got req=%b done=%b, required req=%b done=0",
                         bus.rd_split_req, bus.rd_xfer_done, e.is_split);
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (bus.rd_split_req !== 1'b1 || bus.rd_next_addr !== e.addr ||
                    bus.rd_rem_len !== e.len) begin
                    errors++;
                    $display("FAIL tcem_hold%0d: got req=%b addr=%h len=%0d, required 1 %h %0d",
                             i, bus.rd_split_req, bus.rd_next_addr, bus.rd_rem_len, e.addr, e.len);
                end
                cyc(1'b0, 1'b1, 1'b0, i == 3);
            end
            checks++;
            if (bus.rd_split_req !== 1'b0 || dut.state_q !== 2'd0) begin
                errors++;
                $display("FAIL tcem_ack: got req=%b state=%0d, required 0 0",
                         bus.rd_split_req, dut.state_q);
            end
            checks++;
            if (bus.rd_next_addr !== e.addr || bus.rd_rem_len !== e.len) begin
                errors++;
                $display("FAIL tcem_keep: got addr=%h len=%0d, required %h %0d",
                         bus.rd_next_addr, bus.rd_rem_len, e.addr, e.len);
            end
        end
    endtask

    task automatic test_wrap_split();
        bit   to;
        exp_t e;
        start(32'h3C, 10'd16, 2'b10, 1'b0);
        exp_q.push_back('{is_split: 1'b1, addr: 32'h24, len: 10'd12});
        beats(4);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        wait_ev(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL wrap_event: got timeout, required rd_split_req");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rd_split_req !== e.is_split || bus.rd_next_addr !== e.addr ||
                bus.rd_rem_len !== e.len) begin
                errors++;
                $display("FAIL wrap_req: got req=%b addr=%h len=%0d, required %b %h %0d",
                         bus.rd_split_req, bus.rd_next_addr, bus.rd_rem_len,
                         e.is_split, e.addr, e.len);
            end
            cyc(1'b0, 1'b1, 1'b0, 1'b1);   // ack in the first request cycle
            checks++;
            if (bus.rd_split_req !== 1'b0) begin
                errors++;
                $display("FAIL wrap_ack: got req=%b, required 0", bus.rd_split_req);
            end
        end
    endtask

    task automatic test_last_beat_tcem();
        bit   to;
        exp_t e;
        start(32'h80, 10'd8, 2'b01, 1'b0);
        exp_q.push_back('{is_split: 1'b0, addr: 32'h0, len: 10'd0});
        beats(7);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);   // last beat with tCEM expiry
        cyc(1'b1, 1'b0, 1'b0, 1'b0);   // surplus beat must not underflow
        wait_ev(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL last_event: got timeout, required rd_xfer_done");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rd_split_req !== e.is_split || bus.rd_xfer_done !== !e.is_split) begin
                errors++;
                $display("FAIL last_kind: got req=%b done=%b, required req=%b done=%b",
                         bus.rd_split_req, bus.rd_xfer_done, e.is_split, !e.is_split);
            end
        end
    endtask

    task automatic test_write_and_reset();
        bit   to;
        bit   seen;
        exp_t e;
        seen = 1'b0;
        start(32'h500, 10'd8, 2'b01, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, i == 2, 1'b0);
            seen |= bus.rd_split_req | bus.rd_xfer_done;
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            seen |= bus.rd_split_req | bus.rd_xfer_done;
        end
        checks++;
        if (seen !== 1'b0 || dut.state_q !== 2'd0) begin
            errors++;
            $display("FAIL write_ignored: got event=%b state=%0d, required 0 0",
                     seen, dut.state_q);
        end
        start(32'h400, 10'd4, 2'b01, 1'b0);
        exp_q.push_back('{is_split: 1'b1, addr: 32'h402, len: 10'd3});
        beats(1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        wait_ev(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL rst_event: got timeout, required rd_split_req");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rd_split_req !== e.is_split || bus.rd_next_addr !== e.addr ||
                bus.rd_rem_len !== e.len) begin
                errors++;
                $display("FAIL rst_req: got req=%b addr=%h len=%0d, required %b %h %0d",
                         bus.rd_split_req, bus.rd_next_addr, bus.rd_rem_len,
                         e.is_split, e.addr, e.len);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.rd_split_req, bus.rd_xfer_done, bus.rd_next_addr, bus.rd_rem_len} !== '0 ||
            dut.state_q !== 2'd0) begin
            errors++;
            $display("FAIL rst_async: got req=%b done=%b addr=%h len=%0d state=%0d, required 0",
                     bus.rd_split_req, bus.rd_xfer_done, bus.rd_next_addr, bus.rd_rem_len,
                     dut.state_q);
        end
        @(posedge mem_clk);
        #1 rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_page_boundary();
        bit   to;
        exp_t e;
        bus.mem_page_size = 4'd6;
        start(32'h38, 10'd16, 2'b01, 1'b0);
`ifdef RD_PG_BNDRY_SPLIT_EN
        exp_q.push_back('{is_split: 1'b1, addr: 32'h40, len: 10'd12});
        beats(4);
`else
        exp_q.push_back('{is_split: 1'b0, addr: 32'h0, len: 10'd0});
        beats(16);
`endif
        wait_ev(to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL page_event: got timeout, required an event");
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.rd_split_req !== e.is_split || bus.rd_xfer_done !== !e.is_split) begin
                errors++;
                $display("FAIL page_kind: got req=%b done=%b, required req=%b done=%b",
                         bus.rd_split_req, bus.rd_xfer_done, e.is_split, !e.is_split);
            end
            if (e.is_split) begin
                checks++;
                if (bus.rd_next_addr !== e.addr || bus.rd_rem_len !== e.len) begin
                    errors++;
                    $display("FAIL page_req: got addr=%h len=%0d, required %h %0d",
                             bus.rd_next_addr, bus.rd_rem_len, e.addr, e.len);
                end
                cyc(1'b0, 1'b1, 1'b0, 1'b1);
            end
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        bus.tcem_expired  = 1'b0;
        bus.mem_page_size = 4'd6;
        bus.start_track   = 1'b0;
        bus.first_addr    = '0;
        bus.wr_rd         = 1'b0;
        bus.xfer_btype    = 2'b01;
        bus.xfer_mem_len  = '0;
        bus.rd_beat_valid = 1'b0;
        bus.ce_n_ip       = 1'b1;
        bus.rd_split_ack  = 1'b0;
        test_reset();
        test_incr_done();
        test_tcem_split();
        test_wrap_split();
        test_last_beat_tcem();
        test_write_and_reset();
        test_page_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
